alu_rs: RTL

// Reservation station that feeds the combinational ALU.
// - Buffers dispatched ALU ops (compare / op / opi) until both operands are valid.
// - Snoops the CDB to wake waiting operands.
// - Drives one ready op per cycle onto the ALU input bus.
// - Registers the ALU result and broadcasts it with its ROB tag.

---
 rtl/alu_rs_if.sv | 52 +++++
 rtl/alu_rs.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_if.sv
// Bundle of the dispatch, CDB, ALU and result buses around the ALU reservation station.
interface alu_rs_if #(
    parameter int TAG_W = 4
);
    logic             disp_valid;
    logic [1:0]       disp_type;
    logic [2:0]       disp_details;
    logic             disp_diff;
    logic             disp_q1_valid;
    logic [TAG_W-1:0] disp_q1;
    logic [31:0]      disp_v1;
    logic             disp_q2_valid;
    logic [TAG_W-1:0] disp_q2;
    logic [31:0]      disp_v2;
    logic [TAG_W-1:0] disp_dest;
    logic             full;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;

    logic [1:0]       alu_type;
    logic [2:0]       alu_details;
    logic             alu_diff;
    logic [31:0]      alu_r1;
    logic [31:0]      alu_r2;
    logic [31:0]      alu_out;

    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_value;

    // The station itself
    modport slave (
        input  disp_valid, disp_type, disp_details, disp_diff,
               disp_q1_valid, disp_q1, disp_v1,
               disp_q2_valid, disp_q2, disp_v2, disp_dest,
               cdb_valid, cdb_tag, cdb_value, alu_out,
        output full, alu_type, alu_details, alu_diff, alu_r1, alu_r2,
               res_valid, res_tag, res_value
    );

    // Dispatch unit, CDB and the combinational ALU around the station
    modport master (
        output disp_valid, disp_type, disp_details, disp_diff,
               disp_q1_valid, disp_q1, disp_v1,
               disp_q2_valid, disp_q2, disp_v2, disp_dest,
               cdb_valid, cdb_tag, cdb_value, alu_out,
        input  full, alu_type, alu_details, alu_diff, alu_r1, alu_r2,
               res_valid, res_tag, res_value
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers ops until operands arrive, wakes them from the
// CDB, issues the lowest ready slot to the ALU each cycle and registers the result.
module alu_rs #(
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush_in,
    alu_rs_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_WAIT  = 2'd1,
        SLOT_READY = 2'd2
    } slot_state_t;

    slot_state_t      slot_state     [ENTRIES];
    slot_state_t      slot_state_nxt [ENTRIES];
    logic [1:0]       s_type         [ENTRIES];
    logic [2:0]       s_details      [ENTRIES];
    logic             s_diff         [ENTRIES];
    logic [TAG_W-1:0] s_q1           [ENTRIES];
    logic [31:0]      s_v1           [ENTRIES];
    logic [TAG_W-1:0] s_q2           [ENTRIES];
    logic [31:0]      s_v2           [ENTRIES];
    logic [TAG_W-1:0] s_dest         [ENTRIES];
    logic [ENTRIES-1:0] q1_pend;
    logic [ENTRIES-1:0] q2_pend;
    logic [ENTRIES-1:0] wake1;
    logic [ENTRIES-1:0] wake2;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             ready_found;
    logic [IDX_W-1:0] issue_idx;
    logic             accept;
    logic             issue_fire;
    logic             d1_hit;
    logic             d2_hit;
    logic             d1_pend;
    logic             d2_pend;
    logic [31:0]      d1_val;
    logic [31:0]      d2_val;

    assign accept     = bus.disp_valid & free_found & rdy_in & ~flush_in;
    assign issue_fire = ready_found & rdy_in & ~flush_in;

    // An operand broadcast on the CDB in the dispatch cycle is captured directly
    assign d1_hit  = bus.disp_q1_valid & bus.cdb_valid & (bus.cdb_tag == bus.disp_q1);
    assign d2_hit  = bus.disp_q2_valid & bus.cdb_valid & (bus.cdb_tag == bus.disp_q2);
    assign d1_pend = bus.disp_q1_valid & ~d1_hit;
    assign d2_pend = bus.disp_q2_valid & ~d2_hit;
    assign d1_val  = d1_hit ? bus.cdb_value : bus.disp_v1;
    assign d2_val  = d2_hit ? bus.cdb_value : bus.disp_v2;

    // Priority pick of the lowest free slot (dispatch target) and lowest ready slot (issue)
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        issue_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (slot_state[i] == SLOT_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (slot_state[i] == SLOT_READY) begin
                ready_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    // Per-operand CDB match for waiting slots; frozen while the core is not ready
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            wake1[i] = rdy_in && !flush_in && (slot_state[i] == SLOT_WAIT) && q1_pend[i]
                       && bus.cdb_valid && (s_q1[i] == bus.cdb_tag);
            wake2[i] = rdy_in && !flush_in && (slot_state[i] == SLOT_WAIT) && q2_pend[i]
                       && bus.cdb_valid && (s_q2[i] == bus.cdb_tag);
        end
    end

    // Slot next-state: flush clears everything, otherwise dispatch / wake / issue transitions
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            slot_state_nxt[i] = slot_state[i];
            if (flush_in) begin
                slot_state_nxt[i] = SLOT_FREE;
            end else if (rdy_in) begin
                case (slot_state[i])
                    SLOT_FREE: begin
                        if (accept && (free_idx == IDX_W'(i)))
                            slot_state_nxt[i] = (d1_pend || d2_pend) ? SLOT_WAIT : SLOT_READY;
                    end
                    SLOT_WAIT: begin
                        if ((!q1_pend[i] || wake1[i]) && (!q2_pend[i] || wake2[i]))
                            slot_state_nxt[i] = SLOT_READY;
                    end
                    SLOT_READY: begin
                        if (issue_fire && (issue_idx == IDX_W'(i)))
                            slot_state_nxt[i] = SLOT_FREE;
                    end
                    default: slot_state_nxt[i] = SLOT_FREE;
                endcase
            end
        end
    end

    // Slot state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) slot_state[i] <= SLOT_FREE;
        end else begin
            slot_state <= slot_state_nxt;
        end
    end

    // Slot payload: load on dispatch, capture woken operand values from the CDB
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            q1_pend <= '0;
            q2_pend <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                s_type[i]    <= '0;
                s_details[i] <= '0;
                s_diff[i]    <= 1'b0;
                s_q1[i]      <= '0;
                s_v1[i]      <= '0;
                s_q2[i]      <= '0;
                s_v2[i]      <= '0;
                s_dest[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (accept && (free_idx == IDX_W'(i))) begin
                    s_type[i]    <= bus.disp_type;
                    s_details[i] <= bus.disp_details;
                    s_diff[i]    <= bus.disp_diff;
                    s_q1[i]      <= bus.disp_q1;
                    s_v1[i]      <= d1_val;
                    s_q2[i]      <= bus.disp_q2;
                    s_v2[i]      <= d2_val;
                    s_dest[i]    <= bus.disp_dest;
                    q1_pend[i]   <= d1_pend;
                    q2_pend[i]   <= d2_pend;
                end else begin
                    if (wake1[i]) begin
                        q1_pend[i] <= 1'b0;
                        s_v1[i]    <= bus.cdb_value;
                    end
                    if (wake2[i]) begin
                        q2_pend[i] <= 1'b0;
                        s_v2[i]    <= bus.cdb_value;
                    end
                end
            end
        end
    end

    // Station outputs: full flag and the ALU operand bus, zeroed when nothing issues
    always_comb begin
        bus.full        = !free_found;
        bus.alu_type    = '0;
        bus.alu_details = '0;
        bus.alu_diff    = 1'b0;
        bus.alu_r1      = '0;
        bus.alu_r2      = '0;
        if (issue_fire) begin
            bus.alu_type    = s_type[issue_idx];
            bus.alu_details = s_details[issue_idx];
            bus.alu_diff    = s_diff[issue_idx];
            bus.alu_r1      = s_v1[issue_idx];
            bus.alu_r2      = s_v2[issue_idx];
        end
    end

    // Result register: one-cycle valid pulse per issued op, held while frozen
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bus.res_valid <= 1'b0;
            bus.res_tag   <= '0;
            bus.res_value <= '0;
        end else if (flush_in) begin
            bus.res_valid <= 1'b0;
        end else if (rdy_in) begin
            bus.res_valid <= issue_fire;
            if (issue_fire) begin
                bus.res_tag   <= s_dest[issue_idx];
                bus.res_value <= bus.alu_out;
            end
        end
    end
endmodule
